// File: rtl/issue_allocator.sv
// In-order dispatch queue with CDB operand snooping; issues the head entry to a free ALU, LS or branch unit.
// Optional `ALLOC_RR_EN selects a round-robin ALU arbiter instead of fixed lowest-index priority.
module issue_allocator #(
   parameter int unsigned NUM_ALU = 3,
   parameter int unsigned QDEPTH  = 4,
   parameter int unsigned NUM_CDB = 4,
   parameter int unsigned TAG_W   = 3,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush_in,
   input  logic                      in_valid_in,
   output logic                      in_ready_out,
   input  logic [7:0]                op_in,
   input  logic [ADDR_W-1:0]         pc_in,
   input  logic [WORD_W-1:0]         imm_in,
   input  logic [WORD_W-1:0]         datax_in,
   input  logic [WORD_W-1:0]         datay_in,
   input  logic [TAG_W-1:0]          tagx_in,
   input  logic [TAG_W-1:0]          tagy_in,
   input  logic [RADDR_W-1:0]        addrw_in,
   input  logic [NUM_CDB-1:0]        cdb_en_in,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_in,
   input  logic [NUM_CDB*WORD_W-1:0] cdb_data_in,
   input  logic [NUM_ALU-1:0]        alu_busy_in,
   input  logic                      ls_busy_in,
   input  logic                      branch_busy_in,
   output logic [NUM_ALU-1:0]        alu_en_out,
   output logic                      ls_en_out,
   output logic                      branch_en_out,
   output logic [3:0]                iss_op_out,
   output logic [ADDR_W-1:0]         iss_pc_out,
   output logic [WORD_W-1:0]         iss_imm_out,
   output logic [WORD_W-1:0]         iss_datax_out,
   output logic [WORD_W-1:0]         iss_datay_out,
   output logic [TAG_W-1:0]          iss_tagx_out,
   output logic [TAG_W-1:0]          iss_tagy_out,
   output logic [RADDR_W-1:0]        iss_addrw_out,
   output logic                      en_mod_out,
   output logic [RADDR_W-1:0]        reg_addr_out,
   output logic [TAG_W-1:0]          reg_tag_out
);

   localparam int unsigned PW  = $clog2(QDEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned RRW = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

   typedef struct packed {
      logic [7:0]         op;
      logic [ADDR_W-1:0]  pc;
      logic [WORD_W-1:0]  imm;
      logic [WORD_W-1:0]  datax;
      logic [WORD_W-1:0]  datay;
      logic [TAG_W-1:0]   tagx;
      logic [TAG_W-1:0]   tagy;
      logic [RADDR_W-1:0] addrw;
   } entry_t;

   // Lowest-numbered matching CDB port wins when several carry the same tag.
   function automatic entry_t snoop_entry(input entry_t e);
      entry_t r;
      logic   hx;
      logic   hy;
      r  = e;
      hx = 1'b0;
      hy = 1'b0;
      for (int unsigned p = 0; p < NUM_CDB; p++) begin
         if (cdb_en_in[p] && !hx && (e.tagx != '0) && (cdb_tag_in[p*TAG_W +: TAG_W] == e.tagx)) begin
            r.tagx  = '0;
            r.datax = cdb_data_in[p*WORD_W +: WORD_W];
            hx      = 1'b1;
         end
         if (cdb_en_in[p] && !hy && (e.tagy != '0) && (cdb_tag_in[p*TAG_W +: TAG_W] == e.tagy)) begin
            r.tagy  = '0;
            r.datay = cdb_data_in[p*WORD_W +: WORD_W];
            hy      = 1'b1;
         end
      end
      return r;
   endfunction

   entry_t           ent_q [QDEPTH];
   entry_t           ent_d [QDEPTH];
   entry_t           snp   [QDEPTH];
   entry_t           in_ent;
   entry_t           in_snp;
   entry_t           head;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             head_valid, is_alu, is_ls, is_br, is_nop;
   logic             issue, deq, enq, alu_found;
   logic [3:0]       cls;
   logic [TAG_W-1:0] grant_tag;
   int unsigned      alu_grant;

   assign in_ready_out = (count_q < CW'(QDEPTH));
   assign enq          = in_valid_in && in_ready_out && !flush_in;

   always_comb begin
      in_ent       = '0;
      in_ent.op    = op_in;
      in_ent.pc    = pc_in;
      in_ent.imm   = imm_in;
      in_ent.datax = datax_in;
      in_ent.datay = datay_in;
      in_ent.tagx  = tagx_in;
      in_ent.tagy  = tagy_in;
      in_ent.addrw = addrw_in;
      in_snp       = snoop_entry(in_ent);
      for (int unsigned i = 0; i < QDEPTH; i++) begin
         snp[i] = snoop_entry(ent_q[i]);
      end
   end

   assign head       = snp[head_q];
   assign head_valid = (count_q != '0);
   assign cls        = head.op[7:4];

   always_comb begin
      is_alu = (cls == 4'b0001) || (cls == 4'b0010) || (cls == 4'b0101) || (cls == 4'b1101);
      is_ls  = (cls == 4'b0011) || (cls == 4'b1001);
      is_br  = (cls == 4'b0100);
      is_nop = !(is_alu || is_ls || is_br);
   end

`ifdef ALLOC_RR_EN
   logic [RRW-1:0] rr_q, rr_d;

   always_comb begin
      int unsigned idx;
      idx       = 0;
      alu_found = 1'b0;
      alu_grant = 0;
      for (int unsigned off = 0; off < NUM_ALU; off++) begin
         idx = 32'(rr_q) + off;
         if (idx >= NUM_ALU) idx = idx - NUM_ALU;
         if (!alu_found && !alu_busy_in[idx]) begin
            alu_found = 1'b1;
            alu_grant = idx;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (flush_in) begin
         rr_d = '0;
      end else if (issue && is_alu) begin
         rr_d = (alu_grant + 1 >= NUM_ALU) ? '0 : RRW'(alu_grant + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rr_q <= '0;
      else     rr_q <= rr_d;
   end
`else
   always_comb begin
      alu_found = 1'b0;
      alu_grant = 0;
      for (int unsigned a = 0; a < NUM_ALU; a++) begin
         if (!alu_found && !alu_busy_in[a]) begin
            alu_found = 1'b1;
            alu_grant = a;
         end
      end
   end
`endif

   always_comb begin
      issue = head_valid && ((is_alu && alu_found) || (is_ls && !ls_busy_in) || (is_br && !branch_busy_in));
      deq   = head_valid && (issue || is_nop);
      if (is_alu)     grant_tag = TAG_W'(alu_grant + 1);
      else if (is_ls) grant_tag = TAG_W'(NUM_ALU + 1);
      else            grant_tag = TAG_W'(NUM_ALU + 2);
   end

   always_comb begin
      alu_en_out    = '0;
      ls_en_out     = 1'b0;
      branch_en_out = 1'b0;
      en_mod_out    = 1'b0;
      reg_tag_out   = '0;
      iss_op_out    = '0;
      iss_pc_out    = '0;
      iss_imm_out   = '0;
      iss_datax_out = '0;
      iss_datay_out = '0;
      iss_tagx_out  = '0;
      iss_tagy_out  = '0;
      iss_addrw_out = '0;
      reg_addr_out  = '0;
      if (head_valid) begin
         iss_op_out    = head.op[3:0];
         iss_pc_out    = head.pc;
         iss_imm_out   = head.imm;
         iss_datax_out = head.datax;
         iss_datay_out = head.datay;
         iss_tagx_out  = head.tagx;
         iss_tagy_out  = head.tagy;
         iss_addrw_out = head.addrw;
         reg_addr_out  = head.addrw;
      end
      if (issue) begin
         reg_tag_out = grant_tag;
         if (is_alu) begin
            for (int unsigned a = 0; a < NUM_ALU; a++) begin
               alu_en_out[a] = (a == alu_grant);
            end
            en_mod_out = 1'b1;
         end else if (is_ls) begin
            ls_en_out  = 1'b1;
            en_mod_out = (cls == 4'b1001);
         end else begin
            branch_en_out = 1'b1;
         end
      end
   end

   // Queued entries are re-snooped every cycle, so ent_d starts from the snooped image.
   always_comb begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
         ent_d[i] = snp[i];
      end
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) begin
            ent_d[tail_q] = in_snp;
            tail_d        = tail_q + PW'(1);
         end
         if (deq) head_d = head_q + PW'(1);
         count_d = count_q + CW'(enq) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: doc/issue_allocator.md
# issue_allocator

Parametrised in-order dispatch stage for the out-of-order core. It buffers decoded instructions in a small FIFO and keeps waiting source operands current by snooping the common data bus (CDB). Each cycle it issues the head entry to one free functional unit: one of NUM_ALU ALUs, the load/store unit or the branch unit. On issue it drives the rename-table tag update. It sits between decode/register-read and the reservation stations. It replaces the single-slot, three-ALU fixed allocator.

## Interface
- NUM_ALU, 3: number of ALU reservation stations (1..6)
- QDEPTH, 4: queue entries, power of two (2..16)
- NUM_CDB, 4: CDB broadcast ports snooped
- TAG_W, 3: tag width; must hold NUM_ALU+2; tag 0 = UNLOCKED
- WORD_W, 32; ADDR_W, 32; RADDR_W, 5
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_in  in  1  discard all queued entries (mispredict)
- in_valid_in  in  1  decode presents an instruction
- in_ready_out  out  1  queue not full
- op_in  in  8  [7:4] class, [3:0] sub-op
- pc_in, imm_in  in  ADDR_W, WORD_W  instruction pc, immediate
- datax_in, datay_in  in  WORD_W  operand values
- tagx_in, tagy_in  in  TAG_W  operand producer tags (0 = value valid)
- addrw_in  in  RADDR_W  destination register
- cdb_en_in  in  NUM_CDB  per-port broadcast valid
- cdb_tag_in  in  NUM_CDB*TAG_W  flattened broadcast tags
- cdb_data_in  in  NUM_CDB*WORD_W  flattened broadcast data
- alu_busy_in  in  NUM_ALU  per-ALU station busy
- ls_busy_in, branch_busy_in  in  1  station busy
- alu_en_out  out  NUM_ALU  one-hot ALU issue strobe
- ls_en_out, branch_en_out  out  1  issue strobes
- iss_op_out  out  4  sub-op
- iss_pc_out, iss_imm_out  out  ADDR_W, WORD_W
- iss_datax_out, iss_datay_out  out  WORD_W  forwarded operands
- iss_tagx_out, iss_tagy_out  out  TAG_W  forwarded tags
- iss_addrw_out  out  RADDR_W
- en_mod_out  out  1  rename-table write
- reg_addr_out  out  RADDR_W; reg_tag_out  out  TAG_W

## Operation
- FIFO with head pointer, tail pointer and count (log2(QDEPTH)+1 bits); pointers wrap modulo QDEPTH.
- Enqueue when in_valid_in && in_ready_out.
- in_ready_out = count < QDEPTH. There is no same-cycle full bypass.
- CDB snoop:
  - Every cycle, each valid entry with a nonzero tag equal to an enabled cdb_tag_in captures that port's data and clears the tag.
  - Incoming operands are snooped the same way before they are written.
  - If two ports match the same tag, the lowest port wins.
- Head issue is combinational, using head operands forwarded from the current-cycle CDB:
  - Classes 0001/0010/0101/1101 issue to a free ALU chosen by arbiter. Tag = ALU index+1; en_mod_out=1.
  - Classes 0011/1001 issue to LS when free. Tag = NUM_ALU+1. en_mod_out=1 only for 1001 (load). Store issues with en_mod_out=0.
  - Class 0100 issues to branch when free. en_mod_out=0.
  - Any other class: dequeued with no strobe and no rename write (nop).
  - Target busy: head stalls and all strobes are 0.
- reg_addr_out = head addrw; reg_tag_out = the granted tag, or 0 when there is no issue.
- Dequeue at the edge when the head issued or was a nop. Simultaneous enqueue and dequeue leaves count unchanged.
- flush_in: count and pointers go to 0 and the queue is empty next cycle. The same-cycle enqueue is dropped. Same-cycle issue strobes are still driven, and the caller ignores them.

## Timing
- Reset (and flush):
  - Queue empty, pointers 0, round-robin pointer 0.
  - in_ready_out=1; all strobes, en_mod_out and reg_tag_out are 0.
  - Payload outputs are don't-care but must be driven 0 while empty.
- Minimum enqueue-to-issue latency is 1 cycle: an entry written at edge N is at the head from N.
- At most one issue per cycle.
- A CDB broadcast in the same cycle as issue is reflected in the iss_* outputs with zero latency.
- rst has priority over flush_in, and flush_in has priority over enqueue and dequeue.

## Configuration
- ALLOC_RR_EN defined:
  - ALU arbiter is round-robin. The search starts at the round-robin pointer.
  - On an ALU grant the pointer moves to granted+1 mod NUM_ALU.
- ALLOC_RR_EN undefined:
  - Fixed priority, lowest free ALU index wins.
  - No pointer register exists.

## Test plan
- Reset, then enqueue 4 ALU ops with all ALUs free -> issue order ALU0, ALU1, ALU2, ALU0 with RR; ALU0 each time without RR. reg_tag_out is 1, 2, 3, 1 (RR).
- Fill queue with ls_busy_in=1 -> in_ready_out=0 after the 4th enqueue. Release -> one issue per cycle and in_ready_out=1 again.
- Queued entry with tagx=2, then CDB port 1 broadcasts tag 2 with data 0xDEADBEEF on the issue cycle -> iss_datax_out=0xDEADBEEF and iss_tagx_out=0.
- Store (class 0011) issues -> ls_en_out=1, en_mod_out=0. Load (1001) -> en_mod_out=1 and reg_tag_out=NUM_ALU+1.
- flush_in with 3 entries and a concurrent enqueue -> next cycle the queue is empty, no strobes, in_ready_out=1.
- Class 0000 at head -> dequeued in 1 cycle with no strobe and no rename write.
